wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage directly downstream of the load/store stage in the 5-stage RV64 pipeline. It registers the LS-stage results behind a valid/ready handshake, selects the architectural write-back value, and drives the register-file write port. It also provides the wb_data/instr_last forwarding pair consumed by the LS stage, counts retired instructions, and halts the core on a committed ebreak.

Parameters:
XLEN, 64, datapath width
INST_LEN, 32, instruction width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ls_valid_i  in  1  LS stage presents an instruction
ls_ready_o  out  1  WB can accept this cycle
pc_i  in  XLEN  PC of the LS instruction
instr_i  in  INST_LEN  instruction from LS
alures_i  in  XLEN  ALU result / effective address
ls_res_i  in  XLEN  load data from LS (already extended)
csr_data_i  in  XLEN  old CSR value for CSR instructions
trap_i  in  1  instruction trapped in LS (ecall/exception)
flush_i  in  1  kill the WB-resident instruction
stall_i  in  1  external hold (sim/debug); freezes WB
rd_wen_o  out  1  register-file write enable
rd_addr_o  out  5  destination register
rd_data_o  out  XLEN  write-back value
wb_data_o  out  XLEN  forwarded value (= rd_data_o, held while valid)
instr_last_o  out  INST_LEN  instruction in WB, NOP (32'h13) when empty
commit_o  out  1  one-cycle retire pulse
commit_pc_o  out  XLEN  PC of retiring instruction
instret_o  out  64  retired-instruction count
halt_o  out  1  ebreak committed; core halted

Behaviour:
- One clock, asynchronous active-low reset: every output and internal register clears on rst_n low regardless of clk.
- Reset values: all outputs 0 except instr_last_o = 32'h0000_0013 and ls_ready_o = 1. The FSM resets to EMPTY.
- FSM states: EMPTY, FULL, HALTED.
- EMPTY → FULL when ls_valid_i & ls_ready_o. Capture pc, instr, alures, ls_res, csr_data and trap on that edge.
- FULL → FULL when it retires and a new instruction is accepted in the same cycle. This gives back-to-back throughput of 1 instruction per cycle.
- FULL → EMPTY when it retires with no new input, or on flush_i.
- FULL → HALTED when the retiring instruction is ebreak (32'h0010_0073).
- HALTED is terminal until reset: ls_ready_o = 0, no writes, no commits, halt_o = 1.
- ls_ready_o = (state == EMPTY) | (state == FULL & ~stall_i & ~flush_i). It is 0 in HALTED.
- Retire condition: state FULL & ~stall_i & ~flush_i. When it holds, commit_o = 1 and commit_pc_o = the registered pc, both combinational from the register. instret_o increments on the same edge and wraps modulo 2^64.
- Write-back select, decoded from the registered instr[6:2]:
  - load (00000) → ls_res
  - jal (11011) or jalr (11001) → pc + 4
  - system (11100) with funct3 != 0 → csr_data
  - all others → alures
- rd_wen_o = retire & writes_rd & (rd != 0) & ~trap. writes_rd is false for store (01000), branch (11000), and system with funct3 == 0.
- rd_addr_o = instr[11:7]. rd_data_o is the selected value; it is 0 when EMPTY.
- Forwarding: wb_data_o and instr_last_o reflect the WB-resident instruction whenever state is FULL, including while stalled. This lets LS resolve load→store data hazards.
- A trapped instruction still retires (commit_o = 1, instret increments) but never writes rd.
- Priority: flush_i beats stall_i. A flush discards the instruction with no commit and no write, and no new input is accepted that cycle.
- Stall: all registers hold, no commit, no write.
- Reset mid-operation drops any held instruction with no commit.

Test Plan:
- Reset, then ld with rd=x5, ls_res_i=64'hFFFF_FFFF_8000_0000 → the next cycle shows rd_wen_o=1, rd_addr_o=5, rd_data_o=64'hFFFF_FFFF_8000_0000, commit_o=1, instret_o=1 one cycle later.
- jal x1 at pc=64'h8000_0010, then addi x0,x0,1 → rd_data_o=64'h8000_0014 for x1; for the addi, rd_wen_o=0 but commit_o=1.
- sd followed by a load with ls_valid_i held high for 3 consecutive instructions → 3 commit pulses on consecutive cycles, store rd_wen_o=0, instret_o=3.
- Instruction in FULL, stall_i=1 for 4 cycles → ls_ready_o=0, no commit, instr_last_o and wb_data_o stable; on stall release exactly one commit.
- FULL with stall_i=1 and flush_i=1 together → no commit, no write; the next cycle state is EMPTY and ls_ready_o=1.
- ebreak retires → commit_o pulse, then halt_o=1 and ls_ready_o=0 permanently; a later ls_valid_i is ignored until rst_n pulses low, after which instret_o=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: holds one LS-stage result, selects the architectural value,
// drives the register-file write port, forwards to LS, counts retires, halts on ebreak.
module wb_stage #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ls_valid_i,
  output logic                ls_ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [INST_LEN-1:0] instr_i,
  input  logic [XLEN-1:0]     alures_i,
  input  logic [XLEN-1:0]     ls_res_i,
  input  logic [XLEN-1:0]     csr_data_i,
  input  logic                trap_i,
  input  logic                flush_i,
  input  logic                stall_i,
  output logic                rd_wen_o,
  output logic [4:0]          rd_addr_o,
  output logic [XLEN-1:0]     rd_data_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [INST_LEN-1:0] instr_last_o,
  output logic                commit_o,
  output logic [XLEN-1:0]     commit_pc_o,
  output logic [63:0]         instret_o,
  output logic                halt_o
);

  localparam logic [INST_LEN-1:0] INSTR_NOP    = INST_LEN'(32'h0000_0013);
  localparam logic [INST_LEN-1:0] INSTR_EBREAK = INST_LEN'(32'h0010_0073);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [INST_LEN-1:0] r_instr;
  logic [XLEN-1:0]     r_alures;
  logic [XLEN-1:0]     r_ls_res;
  logic [XLEN-1:0]     r_csr_data;
  logic                r_trap;
  logic [63:0]         r_instret;

  logic                w_retire;
  logic                w_accept;
  logic                w_writes_rd;
  logic [XLEN-1:0]     w_wb_value;

  function automatic logic [XLEN-1:0] wb_select(
    input logic [INST_LEN-1:0] instr,
    input logic [XLEN-1:0]     pc,
    input logic [XLEN-1:0]     alures,
    input logic [XLEN-1:0]     ls_res,
    input logic [XLEN-1:0]     csr_data
  );
    logic [XLEN-1:0] val;
    val = alures;
    case (instr[6:2])
      OPC_LOAD:         val = ls_res;
      OPC_JAL, OPC_JALR: val = pc + XLEN'(4);
      OPC_SYSTEM:       if (instr[14:12] != 3'b000) val = csr_data;
      default:          val = alures;
    endcase
    return val;
  endfunction

  // Stores, branches and ecall/ebreak/mret-style system ops have no rd.
  function automatic logic writes_rd(input logic [INST_LEN-1:0] instr);
    logic wr;
    wr = 1'b1;
    case (instr[6:2])
      OPC_STORE, OPC_BRANCH: wr = 1'b0;
      OPC_SYSTEM:            wr = (instr[14:12] != 3'b000);
      default:               wr = 1'b1;
    endcase
    return wr;
  endfunction

  assign w_wb_value  = wb_select(r_instr, r_pc, r_alures, r_ls_res, r_csr_data);
  assign w_writes_rd = writes_rd(r_instr) & (r_instr[11:7] != 5'd0);
  assign w_accept    = ls_valid_i & ls_ready_o;
  assign instret_o   = r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_retire     = 1'b0;
    ls_ready_o   = 1'b0;
    commit_o     = 1'b0;
    commit_pc_o  = '0;
    rd_wen_o     = 1'b0;
    rd_addr_o    = '0;
    rd_data_o    = '0;
    wb_data_o    = '0;
    instr_last_o = INSTR_NOP;
    halt_o       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        ls_ready_o = 1'b1;
        if (ls_valid_i) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        // Forwarding stays live while stalled so LS can resolve load->store hazards.
        w_retire     = ~stall_i & ~flush_i;
        ls_ready_o   = w_retire;
        commit_o     = w_retire;
        commit_pc_o  = w_retire ? r_pc : '0;
        rd_wen_o     = w_retire & w_writes_rd & ~r_trap;
        rd_addr_o    = r_instr[11:7];
        rd_data_o    = w_wb_value;
        wb_data_o    = w_wb_value;
        instr_last_o = r_instr;
        if (flush_i) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_retire) begin
          if (r_instr == INSTR_EBREAK) w_state_nxt = ST_HALTED;
          else if (ls_valid_i)         w_state_nxt = ST_FULL;
          else                         w_state_nxt = ST_EMPTY;
        end
      end
      ST_HALTED: begin
        halt_o = 1'b1;
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Stage capture: LS results latched on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_alures   <= '0;
      r_ls_res   <= '0;
      r_csr_data <= '0;
      r_trap     <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= pc_i;
      r_instr    <= instr_i;
      r_alures   <= alures_i;
      r_ls_res   <= ls_res_i;
      r_csr_data <= csr_data_i;
      r_trap     <= trap_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: an instruction-level reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid_i = 1'b0;
  logic        ls_ready_o;
  logic [63:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic [63:0] alures_i = '0;
  logic [63:0] ls_res_i = '0;
  logic [63:0] csr_data_i = '0;
  logic        trap_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic [63:0] wb_data_o;
  logic [31:0] instr_last_o;
  logic        commit_o;
  logic [63:0] commit_pc_o;
  logic [63:0] instret_o;
  logic        halt_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_LD     = 32'h0000_3283; // ld   x5, 0(x0)
  localparam logic [31:0] I_JAL    = 32'h0000_00EF; // jal  x1, 0
  localparam logic [31:0] I_ADDI0  = 32'h0010_0013; // addi x0, x0, 1
  localparam logic [31:0] I_SD     = 32'h0051_3023; // sd   x5, 0(x2)
  localparam logic [31:0] I_LW     = 32'h0000_2303; // lw   x6, 0(x0)
  localparam logic [31:0] I_ADD    = 32'h0020_83B3; // add  x7, x1, x2
  localparam logic [31:0] I_CSRRW  = 32'h3000_1473; // csrrw x8, mstatus, x0
  localparam logic [31:0] I_JALR   = 32'h0000_01E7; // jalr x3, 0(x0)
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  wb_stage #(.XLEN(64), .INST_LEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ls_valid_i   (ls_valid_i),
    .ls_ready_o   (ls_ready_o),
    .pc_i         (pc_i),
    .instr_i      (instr_i),
    .alures_i     (alures_i),
    .ls_res_i     (ls_res_i),
    .csr_data_i   (csr_data_i),
    .trap_i       (trap_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .rd_wen_o     (rd_wen_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .wb_data_o    (wb_data_o),
    .instr_last_o (instr_last_o),
    .commit_o     (commit_o),
    .commit_pc_o  (commit_pc_o),
    .instret_o    (instret_o),
    .halt_o       (halt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot that is either empty, holding an instruction, or halted.
  logic        m_full = 1'b0;
  logic        m_halt = 1'b0;
  logic [31:0] m_instr = '0;
  logic [63:0] m_pc = '0, m_alu = '0, m_ls = '0, m_csr = '0;
  logic        m_trap = 1'b0;
  logic [63:0] m_instret = '0;

  function automatic logic [63:0] m_value(input logic [31:0] ins, input logic [63:0] pc,
                                          input logic [63:0] alu, input logic [63:0] ls,
                                          input logic [63:0] csr);
    if (ins[6:0] == 7'h03) return ls;
    if (ins[6:0] == 7'h6F || ins[6:0] == 7'h67) return pc + 64'd4;
    if (ins[6:0] == 7'h73 && ins[14:12] != 3'd0) return csr;
    return alu;
  endfunction

  function automatic logic m_writes(input logic [31:0] ins);
    if (ins[11:7] == 5'd0) return 1'b0;
    if (ins[6:0] == 7'h23 || ins[6:0] == 7'h63) return 1'b0;
    if (ins[6:0] == 7'h73 && ins[14:12] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  logic m_go, m_ready;
  assign m_go    = m_full && !stall_i && !flush_i;
  assign m_ready = !m_halt && (!m_full || m_go);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full    <= 1'b0;
      m_halt    <= 1'b0;
      m_instret <= '0;
    end else if (!m_halt) begin
      if (m_go) m_instret <= m_instret + 64'd1;
      if (m_go && m_instr == I_EBREAK) begin
        m_halt <= 1'b1;
        m_full <= 1'b0;
      end else if (ls_valid_i && m_ready) begin
        m_full  <= 1'b1;
        m_instr <= instr_i;
        m_pc    <= pc_i;
        m_alu   <= alures_i;
        m_ls    <= ls_res_i;
        m_csr   <= csr_data_i;
        m_trap  <= trap_i;
      end else if (m_full && (flush_i || m_go)) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_ready", 64'(ls_ready_o), 64'(m_ready));
      check("m_commit", 64'(commit_o), 64'(m_go));
      check("m_wen", 64'(rd_wen_o), 64'(m_go && m_writes(m_instr) && !m_trap));
      check("m_rd_data", rd_data_o, m_full ? m_value(m_instr, m_pc, m_alu, m_ls, m_csr) : 64'd0);
      check("m_instr_last", 64'(instr_last_o), 64'(m_full ? m_instr : 32'h13));
      check("m_halt", 64'(halt_o), 64'(m_halt));
      check("m_instret", instret_o, m_instret);
      if (m_full) begin
        check("m_rd_addr", 64'(rd_addr_o), 64'(m_instr[11:7]));
        check("m_wb_data", wb_data_o, m_value(m_instr, m_pc, m_alu, m_ls, m_csr));
      end
      if (m_go) check("m_commit_pc", commit_pc_o, m_pc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] alu,
                     input logic [63:0] ls, input logic [63:0] csr, input logic tr);
    ls_valid_i = 1'b1;
    instr_i    = ins;
    pc_i       = pc;
    alures_i   = alu;
    ls_res_i   = ls;
    csr_data_i = csr;
    trap_i     = tr;
  endtask

  task automatic idle();
    ls_valid_i = 1'b0;
    trap_i     = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    neg();
    check("rst_ready", 64'(ls_ready_o), 64'd1);
    check("rst_instr_last", 64'(instr_last_o), 64'h13);
    check("rst_commit", 64'(commit_o), 64'd0);
    check("rst_wen", 64'(rd_wen_o), 64'd0);
    check("rst_rd_data", rd_data_o, 64'd0);
    check("rst_wb_data", wb_data_o, 64'd0);
    check("rst_instret", instret_o, 64'd0);
    check("rst_halt", 64'(halt_o), 64'd0);
    cyc();
    rst_n = 1'b1;

    // ld x5 with sign-extended load data
    put(I_LD, 64'h8000_0000, 64'h8000_1000, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0);
    cyc(); idle();
    neg();
    check("ld_wen", 64'(rd_wen_o), 64'd1);
    check("ld_addr", 64'(rd_addr_o), 64'd5);
    check("ld_data", rd_data_o, 64'hFFFF_FFFF_8000_0000);
    check("ld_commit", 64'(commit_o), 64'd1);
    cyc(); neg();
    check("ld_instret", instret_o, 64'd1);
    check("ld_commit_gone", 64'(commit_o), 64'd0);

    // jal x1 then addi x0 back-to-back
    put(I_JAL, 64'h8000_0010, 64'h8000_0100, 64'd0, 64'd0, 1'b0);
    cyc();
    put(I_ADDI0, 64'h8000_0014, 64'd1, 64'd0, 64'd0, 1'b0);
    neg();
    check("jal_data", rd_data_o, 64'h8000_0014);
    check("jal_addr", 64'(rd_addr_o), 64'd1);
    check("jal_wen", 64'(rd_wen_o), 64'd1);
    check("jal_ready", 64'(ls_ready_o), 64'd1);
    cyc(); idle();
    neg();
    check("addi_x0_wen", 64'(rd_wen_o), 64'd0);
    check("addi_x0_commit", 64'(commit_o), 64'd1);
    check("addi_x0_pc", commit_pc_o, 64'h8000_0014);
    cyc();

    // sd, lw, add streamed with valid held high
    put(I_SD, 64'h8000_0020, 64'h8000_2000, 64'd0, 64'd0, 1'b0);
    cyc();
    put(I_LW, 64'h8000_0024, 64'h8000_2008, 64'hFFFF_FFFF_DEAD_BEEF, 64'd0, 1'b0);
    neg();
    check("sd_commit", 64'(commit_o), 64'd1);
    check("sd_wen", 64'(rd_wen_o), 64'd0);
    cyc();
    put(I_ADD, 64'h8000_0028, 64'h123, 64'd0, 64'd0, 1'b0);
    neg();
    check("lw_commit", 64'(commit_o), 64'd1);
    check("lw_data", rd_data_o, 64'hFFFF_FFFF_DEAD_BEEF);
    cyc(); idle();
    neg();
    check("add_commit", 64'(commit_o), 64'd1);
    check("add_data", rd_data_o, 64'h123);
    cyc(); neg();
    check("stream_instret", instret_o, 64'd6);

    // Stall for four cycles with a competing instruction offered
    put(I_ADD, 64'h8000_0030, 64'h55AA, 64'd0, 64'd0, 1'b0);
    cyc();
    stall_i = 1'b1;
    put(I_LW, 64'h8000_0034, 64'd0, 64'h77, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      neg();
      check("stall_ready", 64'(ls_ready_o), 64'd0);
      check("stall_commit", 64'(commit_o), 64'd0);
      check("stall_instr_last", 64'(instr_last_o), 64'(I_ADD));
      check("stall_wb_data", wb_data_o, 64'h55AA);
      cyc();
    end
    stall_i = 1'b0;
    idle();
    neg();
    check("unstall_commit", 64'(commit_o), 64'd1);
    cyc(); neg();
    check("unstall_once", 64'(commit_o), 64'd0);
    check("unstall_instret", instret_o, 64'd7);

    // Flush together with stall
    put(I_CSRRW, 64'h8000_0040, 64'd0, 64'd0, 64'hCAFE, 1'b0);
    cyc(); idle();
    stall_i = 1'b1;
    flush_i = 1'b1;
    neg();
    check("flush_commit", 64'(commit_o), 64'd0);
    check("flush_wen", 64'(rd_wen_o), 64'd0);
    cyc();
    stall_i = 1'b0;
    flush_i = 1'b0;
    neg();
    check("flush_ready", 64'(ls_ready_o), 64'd1);
    check("flush_empty", 64'(instr_last_o), 64'h13);
    check("flush_instret", instret_o, 64'd7);

    // csrrw, jalr, trapped add
    put(I_CSRRW, 64'h8000_0044, 64'h99, 64'd0, 64'h1800, 1'b0);
    cyc();
    put(I_JALR, 64'h8000_0100, 64'h8000_0200, 64'd0, 64'd0, 1'b0);
    neg();
    check("csr_data", rd_data_o, 64'h1800);
    check("csr_addr", 64'(rd_addr_o), 64'd8);
    cyc();
    put(I_ADD, 64'h8000_0108, 64'h77, 64'd0, 64'd0, 1'b1);
    neg();
    check("jalr_data", rd_data_o, 64'h8000_0104);
    check("jalr_addr", 64'(rd_addr_o), 64'd3);
    cyc(); idle();
    neg();
    check("trap_commit", 64'(commit_o), 64'd1);
    check("trap_wen", 64'(rd_wen_o), 64'd0);
    cyc(); neg();
    check("trap_instret", instret_o, 64'd10);

    // ebreak halts the stage until reset
    put(I_EBREAK, 64'h8000_0200, 64'd0, 64'd0, 64'd0, 1'b0);
    cyc(); idle();
    neg();
    check("ebreak_commit", 64'(commit_o), 64'd1);
    check("ebreak_wen", 64'(rd_wen_o), 64'd0);
    check("ebreak_pc", commit_pc_o, 64'h8000_0200);
    cyc(); neg();
    check("halt_set", 64'(halt_o), 64'd1);
    check("halt_ready", 64'(ls_ready_o), 64'd0);
    put(I_ADD, 64'h8000_0204, 64'h5, 64'd0, 64'd0, 1'b0);
    repeat (3) cyc();
    neg();
    check("halt_no_commit", 64'(commit_o), 64'd0);
    check("halt_hold", 64'(halt_o), 64'd1);
    check("halt_instret", instret_o, 64'd11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle();
    #1;
    check("areset_instret", instret_o, 64'd0);
    check("areset_halt", 64'(halt_o), 64'd0);
    check("areset_ready", 64'(ls_ready_o), 64'd1);
    check("areset_instr_last", 64'(instr_last_o), 64'h13);
    cyc();
    rst_n = 1'b1;
    put(I_ADD, 64'h8000_0000, 64'h42, 64'd0, 64'd0, 1'b0);
    cyc(); idle();
    neg();
    check("post_reset_commit", 64'(commit_o), 64'd1);
    check("post_reset_data", rd_data_o, 64'h42);
    cyc(); neg();
    check("post_reset_instret", instret_o, 64'd1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
